// File: rtl/stopwatch_counter_display.sv
// MM:SS stopwatch driven by divided-clock levels, with pause, per-field
// adjust and a 4-digit multiplexed active-low seven-segment display.
// Single clock domain. The divided clocks are sampled as levels, and each
// rising edge becomes a one-cycle enable.
// Optional macro STOPWATCH_DP_EN adds an active-low decimal-point output
// `dp`, which lights the colon position.
module stopwatch_counter_display #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_clk,
  input  logic       adj_clk,
  input  logic       scan_clk,
  input  logic       blink_clk,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       paused
`ifdef STOPWATCH_DP_EN
  ,
  output logic       dp
`endif
);

  localparam logic [7:0] SEC_MAX_BCD = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};
  localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  logic       r_count_prev, r_adj_prev, r_scan_prev, r_blink_q;
  logic       r_paused;
  logic [7:0] r_min, r_sec;
  logic [1:0] r_idx;
  logic [3:0] r_an;
  logic [6:0] r_seg;

  logic       w_count_rise, w_adj_rise, w_scan_rise;
  logic       w_paused_nxt;
  logic [7:0] w_min_nxt, w_sec_nxt;
  logic [1:0] w_idx_nxt;
  logic [3:0] w_digit;
  logic       w_blank;
  logic [3:0] w_an_nxt;
  logic [6:0] w_seg_nxt;

  assign w_count_rise = count_clk & ~r_count_prev;
  assign w_adj_rise   = adj_clk & ~r_adj_prev;
  assign w_scan_rise  = scan_clk & ~r_scan_prev;

  // BCD field increment, wrapping from max to zero.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return '0;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Next counter value from the derived mode; the mode uses the pre-toggle pause flag.
  always_comb begin
    w_min_nxt    = r_min;
    w_sec_nxt    = r_sec;
    w_paused_nxt = r_paused ^ pause_pulse;
    if (adj) begin
      if (w_adj_rise) begin
        if (sel) w_sec_nxt = bcd_inc(r_sec, SEC_MAX_BCD);
        else     w_min_nxt = bcd_inc(r_min, MIN_MAX_BCD);
      end
    end else if (!r_paused && w_count_rise) begin
      w_sec_nxt = bcd_inc(r_sec, SEC_MAX_BCD);
      if (r_sec == SEC_MAX_BCD) w_min_nxt = bcd_inc(r_min, MIN_MAX_BCD);
    end
  end

  // Display drive is computed from next-state values so an/seg move with the index.
  always_comb begin
    w_idx_nxt = r_idx + 2'(w_scan_rise);
    w_digit   = '0;
    w_an_nxt  = 4'b1110;
    case (w_idx_nxt)
      2'd0: begin w_digit = w_sec_nxt[3:0]; w_an_nxt = 4'b1110; end
      2'd1: begin w_digit = w_sec_nxt[7:4]; w_an_nxt = 4'b1101; end
      2'd2: begin w_digit = w_min_nxt[3:0]; w_an_nxt = 4'b1011; end
      default: begin w_digit = w_min_nxt[7:4]; w_an_nxt = 4'b0111; end
    endcase
    w_blank   = adj && r_blink_q && (sel ? !w_idx_nxt[1] : w_idx_nxt[1]);
    w_seg_nxt = w_blank ? '1 : seg7(w_digit);
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count_prev <= 1'b0;
      r_adj_prev   <= 1'b0;
      r_scan_prev  <= 1'b0;
      r_blink_q    <= 1'b0;
      r_paused     <= 1'b0;
      r_min        <= '0;
      r_sec        <= '0;
      r_idx        <= '0;
      r_an         <= 4'b1110;
      r_seg        <= 7'b1000000;
    end else begin
      r_count_prev <= count_clk;
      r_adj_prev   <= adj_clk;
      r_scan_prev  <= scan_clk;
      r_blink_q    <= blink_clk;
      r_paused     <= w_paused_nxt;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
      r_idx        <= w_idx_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign paused = r_paused;

`ifdef STOPWATCH_DP_EN
  logic r_dp;
  logic w_dp_nxt;

  // Colon at the index-2 digit; it blinks while paused.
  always_comb begin
    w_dp_nxt = 1'b1;
    if (w_idx_nxt == 2'd2) w_dp_nxt = w_paused_nxt ? ~r_blink_q : 1'b0;
  end

  // Decimal point is registered alongside seg.
  always_ff @(posedge clk) begin
    if (!rst) r_dp <= 1'b1;
    else      r_dp <= w_dp_nxt;
  end

  assign dp = r_dp;
`endif

endmodule
